// File: rtl/mem_cycle_gen_pkg.sv
// Shared types for the TMS9900-style byte-pair memory cycle engine.
// Bus control bundle, state encoding and counter sizing helper.
package mem_cycle_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_O = 3'd1,
        ST_WAIT_O = 3'd2,
        ST_XFER_O = 3'd3,
        ST_ADDR_E = 3'd4,
        ST_WAIT_E = 3'd5,
        ST_XFER_E = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    localparam int WAIT_CNT_W = 4;

    typedef struct packed {
        logic busy;
        logic done;
        logic memen_n;
        logic dbin;
        logic we_n;
        logic d_oe;
        logic a15;
    } bus_ctl_t;

    localparam bus_ctl_t CTL_IDLE = '{
        busy:    1'b0,
        done:    1'b0,
        memen_n: 1'b1,
        dbin:    1'b0,
        we_n:    1'b1,
        d_oe:    1'b0,
        a15:     1'b0
    };

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_cycle_gen_wait_timer.sv
// Wait-state down-counter and consecutive READY-low timeout counter
// for the memory cycle engine.
module mem_cycle_gen_wait_timer
    import mem_cycle_gen_pkg::*;
#(
    parameter int WAIT_STATES   = 2,
    parameter int READY_TIMEOUT = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    input  logic i_xfer,
    input  logic i_ready,
    output logic o_wait_zero,
    output logic o_timeout_hit
);

    localparam int TO_W = cnt_w(READY_TIMEOUT);
    localparam bit TO_EN = (READY_TIMEOUT > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [TO_W-1:0] TO_LAST =
        (READY_TIMEOUT > 0) ? TO_W'(READY_TIMEOUT - 1) : '0;

    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [TO_W-1:0]       r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (i_load)
                r_wait_cnt <= WAIT_LOAD;
            else if (i_dec && !o_wait_zero)
                r_wait_cnt <= r_wait_cnt - 1'b1;
            // Only an unbroken run of stalled transfer cycles counts
            if (i_xfer && !i_ready && !o_timeout_hit)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
        end
    end

    assign o_wait_zero   = (r_wait_cnt == '0);
    assign o_timeout_hit = TO_EN && i_xfer && !i_ready &&
                           (r_to_cnt == TO_LAST);

endmodule

// File: rtl/mem_cycle_gen.sv
// Word-to-byte-pair external memory cycle engine, odd byte first.
// All bus outputs are registered from the next-state decode.
module mem_cycle_gen
    import mem_cycle_gen_pkg::*;
#(
    parameter int WAIT_STATES   = 2,
    parameter int ADDR_W        = 15,
    parameter int READY_TIMEOUT = 0
) (
    input  logic              i_phi2,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_memen_n,
    output logic              o_dbin,
    output logic              o_we_n,
    output logic [ADDR_W-1:0] o_a_out,
    output logic              o_a15,
    output logic [7:0]        o_d_out,
    output logic              o_d_oe,
    input  logic [7:0]        i_d_in,
    input  logic              i_ready
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_we;
    logic [15:0] r_wdata;

    logic        w_start;
    logic        w_we_nxt;
    logic [15:0] w_wdata_nxt;
    logic        w_err_nxt;
    logic        w_odd_nxt;
    logic        w_even_nxt;
    logic        w_addr_nxt;
    logic        w_load;
    logic        w_dec;
    logic        w_xfer;
    logic        w_wait_zero;
    logic        w_timeout_hit;
    bus_ctl_t    w_ctl_nxt;
    logic [7:0]  w_dout_nxt;

    assign w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_req;
    assign w_load  = (r_state == ST_ADDR_O) || (r_state == ST_ADDR_E);
    assign w_dec   = (r_state == ST_WAIT_O) || (r_state == ST_WAIT_E);
    assign w_xfer  = (r_state == ST_XFER_O) || (r_state == ST_XFER_E);

    assign w_we_nxt    = w_start ? i_we    : r_we;
    assign w_wdata_nxt = w_start ? i_wdata : r_wdata;

    mem_cycle_gen_wait_timer #(
        .WAIT_STATES   (WAIT_STATES),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) u_timer (
        .i_clk         (i_phi2),
        .i_rst         (i_reset),
        .i_load        (w_load),
        .i_dec         (w_dec),
        .i_xfer        (w_xfer),
        .i_ready       (i_ready),
        .o_wait_zero   (w_wait_zero),
        .o_timeout_hit (w_timeout_hit)
    );

    always_comb begin : next_state
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE:
                w_state_nxt = i_req ? ST_ADDR_O : ST_IDLE;
            ST_ADDR_O:
                w_state_nxt = (WAIT_STATES == 0) ? ST_XFER_O : ST_WAIT_O;
            ST_WAIT_O:
                if (w_wait_zero) w_state_nxt = ST_XFER_O;
            ST_XFER_O: begin
                if (i_ready) begin
                    w_state_nxt = ST_ADDR_E;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_ADDR_E:
                w_state_nxt = (WAIT_STATES == 0) ? ST_XFER_E : ST_WAIT_E;
            ST_WAIT_E:
                if (w_wait_zero) w_state_nxt = ST_XFER_E;
            ST_XFER_E: begin
                if (i_ready) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_odd_nxt  = (w_state_nxt == ST_ADDR_O) ||
                        (w_state_nxt == ST_WAIT_O) ||
                        (w_state_nxt == ST_XFER_O);
    assign w_even_nxt = (w_state_nxt == ST_ADDR_E) ||
                        (w_state_nxt == ST_WAIT_E) ||
                        (w_state_nxt == ST_XFER_E);
    assign w_addr_nxt = (w_state_nxt == ST_ADDR_O) ||
                        (w_state_nxt == ST_ADDR_E);

    always_comb begin : bus_outputs
        w_ctl_nxt  = CTL_IDLE;
        w_dout_nxt = 8'h00;
        if (w_odd_nxt || w_even_nxt) begin
            w_ctl_nxt.busy    = 1'b1;
            w_ctl_nxt.memen_n = 1'b0;
            w_ctl_nxt.dbin    = !w_we_nxt;
            w_ctl_nxt.d_oe    = w_we_nxt;
            w_ctl_nxt.a15     = w_odd_nxt;
            // Strobe held off in the address phase so data settles first
            w_ctl_nxt.we_n    = !w_we_nxt || w_addr_nxt;
            if (w_we_nxt)
                w_dout_nxt = w_odd_nxt ? w_wdata_nxt[7:0] : w_wdata_nxt[15:8];
        end
        if (w_state_nxt == ST_DONE)
            w_ctl_nxt.done = 1'b1;
    end

    always_ff @(posedge i_phi2) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_wdata <= '0;
            o_rdata <= '0;
            o_err   <= 1'b0;
            o_a_out <= '0;
            o_d_out <= '0;
            {o_busy, o_done, o_memen_n, o_dbin,
             o_we_n, o_d_oe, o_a15} <= CTL_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            o_err   <= w_err_nxt;
            o_d_out <= w_dout_nxt;
            {o_busy, o_done, o_memen_n, o_dbin,
             o_we_n, o_d_oe, o_a15} <= w_ctl_nxt;
            if (w_start)
                o_a_out <= i_addr;
            // TI bit 0 is the MSB, so the odd byte is the low-order half
            if (!r_we && i_ready && (r_state == ST_XFER_O))
                o_rdata[7:0] <= i_d_in;
            if (!r_we && i_ready && (r_state == ST_XFER_E))
                o_rdata[15:8] <= i_d_in;
        end
    end

endmodule
